// File: rtl/adventure_ctrl.sv
// Text-adventure game controller: turns edge-detected direction presses into
// room moves, resolves the dragon encounter and enforces the move budget.
module adventure_ctrl #(
    parameter int unsigned MAX_MOVES = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       north,
    input  logic       south,
    input  logic       east,
    input  logic       west,
    input  logic       has_sword,
    output logic [2:0] curr_room,
    output logic       win,
    output logic       dead,
    output logic [7:0] moves
);

    typedef enum logic [2:0] {
        CAVE      = 3'b000,
        TUNNEL    = 3'b001,
        RIVER     = 3'b010,
        STASH     = 3'b011,
        DEN       = 3'b100,
        VICTORY   = 3'b101,
        GRAVEYARD = 3'b110,
        UNUSED    = 3'b111
    } room_t;

    localparam logic [3:0] P_N = 4'b1000;
    localparam logic [3:0] P_S = 4'b0100;
    localparam logic [3:0] P_E = 4'b0010;
    localparam logic [3:0] P_W = 4'b0001;

    room_t      room;
    room_t      room_nxt;
    logic [3:0] dirs;
    logic [3:0] prev;
    logic [3:0] press;
    logic       single;
    logic       at_limit;
    logic       accept;

    assign dirs      = {north, south, east, west};
    assign press     = dirs & ~prev;
    assign single    = $onehot(press);
    assign at_limit  = (moves == 8'(MAX_MOVES));
    assign curr_room = room;

    always_comb begin
        room_nxt = room;
        accept   = 1'b0;
        case (room)
            CAVE, TUNNEL, RIVER, STASH: begin
                // The budget check wins over any request in the same cycle.
                if (at_limit) begin
                    room_nxt = GRAVEYARD;
                end else if (single) begin
                    case (room)
                        CAVE: begin
                            if (press == P_E) begin room_nxt = TUNNEL; accept = 1'b1; end
                        end
                        TUNNEL: begin
                            if (press == P_S) begin room_nxt = RIVER; accept = 1'b1; end
                            if (press == P_W) begin room_nxt = CAVE;  accept = 1'b1; end
                        end
                        RIVER: begin
                            if (press == P_N) begin room_nxt = TUNNEL; accept = 1'b1; end
                            if (press == P_W) begin room_nxt = STASH;  accept = 1'b1; end
                            if (press == P_E) begin room_nxt = DEN;    accept = 1'b1; end
                        end
                        default: begin
                            if (press == P_E) begin room_nxt = RIVER; accept = 1'b1; end
                        end
                    endcase
                end
            end
            DEN:                room_nxt = has_sword ? VICTORY : GRAVEYARD;
            VICTORY, GRAVEYARD: room_nxt = room;
            default:            room_nxt = CAVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            room  <= CAVE;
            moves <= '0;
            prev  <= '1;
            win   <= 1'b0;
            dead  <= 1'b0;
        end else begin
            room <= room_nxt;
            prev <= dirs;
            if (accept && (moves < 8'(MAX_MOVES)))
                moves <= moves + 8'd1;
            win  <= (room_nxt == VICTORY);
            dead <= (room_nxt == GRAVEYARD);
        end
    end

endmodule

// File: tb/tb_adventure_ctrl.sv
// Directed bench for adventure_ctrl: default-budget instance plus a
// MAX_MOVES=4 instance sharing the same button stimulus.
module tb_adventure_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       north, south, east, west;
    logic       has_sword, has_sword4;
    logic [2:0] curr_room, curr_room4;
    logic       win, dead, win4, dead4;
    logic [7:0] moves, moves4;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    adventure_ctrl dut (
        .clk(clk), .reset(reset),
        .north(north), .south(south), .east(east), .west(west),
        .has_sword(has_sword),
        .curr_room(curr_room), .win(win), .dead(dead), .moves(moves)
    );

    adventure_ctrl #(.MAX_MOVES(4)) dut4 (
        .clk(clk), .reset(reset),
        .north(north), .south(south), .east(east), .west(west),
        .has_sword(has_sword4),
        .curr_room(curr_room4), .win(win4), .dead(dead4), .moves(moves4)
    );

    // Sword tracker model: latches one cycle after the room reads 011.
    always_ff @(posedge clk) begin
        if (reset) begin
            has_sword  <= 1'b0;
            has_sword4 <= 1'b0;
        end else begin
            if (curr_room == 3'b011)  has_sword  <= 1'b1;
            if (curr_room4 == 3'b011) has_sword4 <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_dirs(input logic [3:0] m);
        {north, south, east, west} = m;
    endtask

    // One-cycle press, returns on the falling edge where the move is visible.
    task automatic press(input logic [3:0] m);
        @(negedge clk) set_dirs(m);
        @(negedge clk) set_dirs(4'b0000);
    endtask

    task automatic do_reset();
        @(negedge clk) begin reset = 1'b1; set_dirs(4'b0000); end
        @(negedge clk);
        @(negedge clk) reset = 1'b0;
    endtask

    task automatic chk_state(input string tag, input logic [2:0] r, input logic [7:0] m,
                             input logic w, input logic d);
        chk({tag, "_room"},  32'(curr_room), 32'(r));
        chk({tag, "_moves"}, 32'(moves),     32'(m));
        chk({tag, "_win"},   32'(win),       32'(w));
        chk({tag, "_dead"},  32'(dead),      32'(d));
    endtask

    localparam logic [3:0] N = 4'b1000, S = 4'b0100, E = 4'b0010, W = 4'b0001;

    initial begin
        // Reset held two cycles with east pressed.
        reset = 1'b1;
        set_dirs(E);
        repeat (2) @(negedge clk);
        chk_state("reset", 3'd0, 8'd0, 1'b0, 1'b0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk_state("held_e", 3'd0, 8'd0, 1'b0, 1'b0);
        east = 1'b0;
        @(negedge clk) east = 1'b1;
        @(negedge clk) east = 1'b0;
        chk_state("reprs_e", 3'd1, 8'd1, 1'b0, 1'b0);

        // Winning path through the stash.
        do_reset();
        press(E); chk_state("win_e1", 3'd1, 8'd1, 1'b0, 1'b0);
        press(S); chk_state("win_s",  3'd2, 8'd2, 1'b0, 1'b0);
        press(W); chk_state("win_w",  3'd3, 8'd3, 1'b0, 1'b0);
        press(E); chk_state("win_e2", 3'd2, 8'd4, 1'b0, 1'b0);
        press(E); chk_state("win_den", 3'd4, 8'd5, 1'b0, 1'b0);
        @(negedge clk);
        chk_state("win_vault", 3'd5, 8'd5, 1'b1, 1'b0);
        press(W); chk_state("win_frozen", 3'd5, 8'd5, 1'b1, 1'b0);

        // No sword: dragon wins.
        do_reset();
        press(E); chk_state("ns_e1", 3'd1, 8'd1, 1'b0, 1'b0);
        press(S); chk_state("ns_s",  3'd2, 8'd2, 1'b0, 1'b0);
        press(E); chk_state("ns_den", 3'd4, 8'd3, 1'b0, 1'b0);
        @(negedge clk);
        chk_state("ns_grave", 3'd6, 8'd3, 1'b0, 1'b1);
        press(W); chk_state("ns_frz_w", 3'd6, 8'd3, 1'b0, 1'b1);
        press(E); chk_state("ns_frz_e", 3'd6, 8'd3, 1'b0, 1'b1);

        // Illegal, simultaneous and held input in the cave.
        do_reset();
        press(N); chk_state("ill_n", 3'd0, 8'd0, 1'b0, 1'b0);
        press(S); chk_state("ill_s", 3'd0, 8'd0, 1'b0, 1'b0);
        press(W); chk_state("ill_w", 3'd0, 8'd0, 1'b0, 1'b0);
        press(N | E); chk_state("ill_ne", 3'd0, 8'd0, 1'b0, 1'b0);
        @(negedge clk) east = 1'b1;
        repeat (10) @(negedge clk);
        chk_state("hold_e", 3'd1, 8'd1, 1'b0, 1'b0);
        east = 1'b0;

        // Move budget of 4 on dut4.
        do_reset();
        press(E); press(W); press(E); press(W);
        chk("lim_room4",  32'(curr_room4), 32'd0);
        chk("lim_moves4", 32'(moves4),     32'd4);
        chk("lim_dead4",  32'(dead4),      32'd0);
        chk("lim_room20", 32'(curr_room),  32'd0);
        @(negedge clk);
        chk("kill_room4",  32'(curr_room4), 32'd6);
        chk("kill_dead4",  32'(dead4),      32'd1);
        chk("kill_moves4", 32'(moves4),     32'd4);
        chk("nokill_room", 32'(curr_room),  32'd0);
        press(E);
        chk("kill_e_room4",  32'(curr_room4), 32'd6);
        chk("kill_e_moves4", 32'(moves4),     32'd4);
        chk("free_e_room",   32'(curr_room),  32'd1);
        chk("free_e_moves",  32'(moves),      32'd5);

        // Reset mid-game, then replay to victory.
        do_reset();
        press(E); press(S);
        chk_state("mid_river", 3'd2, 8'd2, 1'b0, 1'b0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        chk_state("mid_reset", 3'd0, 8'd0, 1'b0, 1'b0);
        press(E); press(S); press(W); press(E); press(E);
        chk_state("replay_den", 3'd4, 8'd5, 1'b0, 1'b0);
        @(negedge clk);
        chk_state("replay_win", 3'd5, 8'd5, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
